// File: rtl/ramp_checker.sv
// ramp_checker: locks onto an incrementing sample stream and counts breaks and wraps in it.
// Define RAMP_CHECKER_TIMEOUT_EN to drop lock after TIMEOUT consecutive idle cycles in LOCKED.
module ramp_checker #(
  parameter int WIDTH      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ramp_valid,
  input  logic [WIDTH-1:0] ramp,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic             timeout
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);

  if (LOCK_COUNT < 2 || LOCK_COUNT > 255 || TIMEOUT < 1) begin : g_param_check
    $error("ramp_checker: LOCK_COUNT must be 2..255 and TIMEOUT at least 1");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [7:0]       good_q, good_d;
  logic             err_d;
  logic [CNT_W-1:0] err_count_d, wrap_count_d;
  logic             match;

  assign match = (ramp == expected_q);

`ifdef RAMP_CHECKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_d;
`endif

  // Next-state logic: each valid sample resynchronises expected, whatever the state.
  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    good_d       = good_q;
    err_d        = 1'b0;
    err_count_d  = err_count;
    wrap_count_d = wrap_count;
`ifdef RAMP_CHECKER_TIMEOUT_EN
    idle_d       = idle_q;
    timeout_d    = 1'b0;
`endif
    if (ramp_valid) begin
      expected_d = ramp + WIDTH'(1);
`ifdef RAMP_CHECKER_TIMEOUT_EN
      idle_d     = '0;
`endif
      unique case (state_q)
        UNLOCKED: begin
          good_d  = 8'd1;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (match) begin
            good_d = good_q + 8'd1;
            if (good_d == LOCK_TARGET) state_d = LOCKED;
          end else begin
            good_d = 8'd1;
          end
        end
        LOCKED: begin
          if (match) begin
            if (ramp == '0 && wrap_count != '1) wrap_count_d = wrap_count + CNT_W'(1);
          end else begin
            err_d   = 1'b1;
            good_d  = 8'd1;
            state_d = ACQUIRE;
            if (err_count != '1) err_count_d = err_count + CNT_W'(1);
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
`ifdef RAMP_CHECKER_TIMEOUT_EN
    else if (state_q == LOCKED) begin
      if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
        state_d   = UNLOCKED;
        timeout_d = 1'b1;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
`endif
  end

  // All outputs are registered so they describe the sample taken on the previous edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      expected_q <= '0;
      good_q     <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      good_q     <= good_d;
      locked     <= (state_d == LOCKED);
      err        <= err_d;
      err_count  <= err_count_d;
      wrap_count <= wrap_count_d;
    end
  end

`ifdef RAMP_CHECKER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q  <= '0;
      timeout <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ramp_checker.sv
// Directed bench for ramp_checker: a run-length model checked every cycle plus literal expectations.
// Two instances share the stimulus; the second uses CNT_W=2 to exercise counter saturation.
module tb_ramp_checker;

  localparam int LC = 4;
  localparam int TO = 8;
`ifdef RAMP_CHECKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ramp_valid = 1'b0;
  logic [15:0] ramp = 16'h0000;

  logic        locked0, err0, timeout0;
  logic [15:0] err_count0, wrap_count0;
  logic        locked1, err1, timeout1;
  logic [1:0]  err_count1, wrap_count1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ramp_checker #(.WIDTH(16), .LOCK_COUNT(LC), .CNT_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ramp_valid(ramp_valid), .ramp(ramp),
    .locked(locked0), .err(err0), .err_count(err_count0),
    .wrap_count(wrap_count0), .timeout(timeout0)
  );

  ramp_checker #(.WIDTH(16), .LOCK_COUNT(LC), .CNT_W(2), .TIMEOUT(TO)) dut_sat (
    .clk(clk), .rst(rst), .ramp_valid(ramp_valid), .ramp(ramp),
    .locked(locked1), .err(err1), .err_count(err_count1),
    .wrap_count(wrap_count1), .timeout(timeout1)
  );

  // Model: lock means the current run of +1 samples is at least LC long.
  int          run = 0;
  int          idle = 0;
  int          errc = 0;
  int          wrapc = 0;
  logic [15:0] prev = 16'h0000;
  bit          m_err = 1'b0;
  bit          m_to = 1'b0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    started = 1'b1;
    m_err   = 1'b0;
    m_to    = 1'b0;
    if (rst) begin
      run = 0; idle = 0; errc = 0; wrapc = 0; prev = 16'h0000;
    end else if (ramp_valid) begin
      idle = 0;
      if (run == 0) begin
        run = 1;
      end else if (ramp == 16'(prev + 16'd1)) begin
        if (run >= LC && ramp == 16'h0000) wrapc++;
        if (run < LC) run++;
      end else begin
        if (run >= LC) begin
          m_err = 1'b1;
          errc++;
        end
        run = 1;
      end
      prev = ramp;
    end else if (TO_EN && run >= LC) begin
      idle++;
      if (idle == TO) begin
        run = 0; idle = 0; m_to = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("model_locked",       32'(locked0),     32'(run >= LC));
      checkOutput("model_err",          32'(err0),        32'(m_err));
      checkOutput("model_timeout",      32'(timeout0),    32'(m_to));
      checkOutput("model_err_count",    32'(err_count0),  32'((errc > 65535) ? 65535 : errc));
      checkOutput("model_wrap_count",   32'(wrap_count0), 32'((wrapc > 65535) ? 65535 : wrapc));
      checkOutput("model_sat_locked",   32'(locked1),     32'(run >= LC));
      checkOutput("model_sat_err",      32'(err1),        32'(m_err));
      checkOutput("model_sat_timeout",  32'(timeout1),    32'(m_to));
      checkOutput("model_sat_err_cnt",  32'(err_count1),  32'((errc > 3) ? 3 : errc));
      checkOutput("model_sat_wrap_cnt", 32'(wrap_count1), 32'((wrapc > 3) ? 3 : wrapc));
    end
  end

  // Drives one cycle of inputs and returns just after the edge that consumed them.
  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] x);
    @(negedge clk);
    rst        = r;
    ramp_valid = v;
    ramp       = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'hABCD);
    checkOutput("reset_locked",   32'(locked0),     32'd0);
    checkOutput("reset_errcnt",   32'(err_count0),  32'd0);
    checkOutput("reset_wrapcnt",  32'(wrap_count0), 32'd0);
    checkOutput("reset_err",      32'(err0),        32'd0);
    checkOutput("reset_timeout",  32'(timeout0),    32'd0);

    for (int i = 0; i <= 16'h10; i++) begin
      applyStimulus(1'b0, 1'b1, 16'(i));
      if (i == 2) checkOutput("lock_not_after_3rd", 32'(locked0), 32'd0);
      if (i == 3) checkOutput("lock_after_4th",     32'(locked0), 32'd1);
    end
    checkOutput("ramp_no_errors", 32'(err_count0), 32'd0);

    applyStimulus(1'b0, 1'b1, 16'h0013);
    checkOutput("skip_err_pulse", 32'(err0),       32'd1);
    checkOutput("skip_err_count", 32'(err_count0), 32'd1);
    checkOutput("skip_unlocked",  32'(locked0),    32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0014);
    checkOutput("skip_err_single", 32'(err0), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0015);
    checkOutput("relock_not_yet", 32'(locked0), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0016);
    checkOutput("relock_done", 32'(locked0), 32'd1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 16'(16'h0017 + i));
      applyStimulus(1'b0, 1'b0, 16'hDEAD);
      checkOutput("toggle_locked", 32'(locked0), 32'd1);
      checkOutput("toggle_no_err", 32'(err0),    32'd0);
    end
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 1'b0, 16'(16'h5A5A ^ i));
      checkOutput("idle_timeout", 32'(timeout0), 32'(TO_EN && i == 7));
    end
    checkOutput("idle_locked", 32'(locked0), 32'(!TO_EN));

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 16'(16'h001A + i));
    checkOutput("post_idle_locked", 32'(locked0), 32'd1);

    applyStimulus(1'b0, 1'b1, 16'h0040);
    for (int i = 1; i < 4; i++) applyStimulus(1'b0, 1'b1, 16'(16'h0040 + i));
    applyStimulus(1'b0, 1'b1, 16'h0050);
    for (int i = 1; i < 4; i++) applyStimulus(1'b0, 1'b1, 16'(16'h0050 + i));
    checkOutput("three_errors", 32'(err_count0), 32'd3);
    checkOutput("three_locked", 32'(locked0),    32'd1);

    applyStimulus(1'b1, 1'b1, 16'h0054);
    checkOutput("midlock_rst_locked",  32'(locked0),     32'd0);
    checkOutput("midlock_rst_errcnt",  32'(err_count0),  32'd0);
    checkOutput("midlock_rst_wrapcnt", 32'(wrap_count0), 32'd0);
    checkOutput("midlock_rst_err",     32'(err0),        32'd0);
    checkOutput("midlock_rst_timeout", 32'(timeout0),    32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'(16'h0055 + i));
    checkOutput("rst_sample_discarded", 32'(locked0), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0058);
    checkOutput("reacquired_after_rst", 32'(locked0), 32'd1);

    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b1, 16'(16'h0100 * k));
      checkOutput("sat_err_pulse", 32'(err0), 32'd1);
      for (int i = 1; i < 4; i++) applyStimulus(1'b0, 1'b1, 16'(16'h0100 * k + i));
    end
    checkOutput("five_errors_wide", 32'(err_count0), 32'd5);
    checkOutput("five_errors_sat",  32'(err_count1), 32'd3);

    applyStimulus(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 16'(16'hFFFB + i));
    checkOutput("wrap_locked_at_fffe", 32'(locked0), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("wrap_count_one", 32'(wrap_count0), 32'd1);
    checkOutput("wrap_no_err",    32'(err0),        32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0001);
    checkOutput("wrap_errcnt_zero", 32'(err_count0), 32'd0);
    checkOutput("wrap_still_locked", 32'(locked0),   32'd1);

    @(negedge clk);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ramp_checker.md
RAMP_CHECKER -- requirements
Module: ramp_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning sample width in bits.
REQ-002 SHALL have parameter LOCK_COUNT, default 4, meaning consecutive correct samples needed to lock (legal range 2..255).
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of err_count and wrap_count.
REQ-004 SHALL have parameter TIMEOUT, default 256, meaning idle cycles before loss of lock (used only under REQ-030).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port ramp_valid, input, 1, high when ramp carries a sample this cycle.
REQ-008 SHALL have port ramp, input, WIDTH, the sample under test, i.e. the rampgen output.
REQ-009 SHALL have port locked, output, 1, high while the FSM is in LOCKED.
REQ-010 SHALL have port err, output, 1, one-cycle pulse per mismatch detected in LOCKED.
REQ-011 SHALL have port err_count, output, CNT_W, saturating count of err pulses.
REQ-012 SHALL have port wrap_count, output, CNT_W, saturating count of 0xFFFF->0x0000 transitions seen in LOCKED.
REQ-013 SHALL have port timeout, output, 1, one-cycle pulse when lock is lost by the idle timeout.

Function
REQ-014 SHALL implement FSM states UNLOCKED, ACQUIRE, LOCKED; any cycle with ramp_valid=0 holds state, expected, and counters, except as stated in REQ-030.
REQ-015 SHALL, in UNLOCKED on a valid sample, load expected=ramp+1 (mod 2^WIDTH), set good=1, and go to ACQUIRE.
REQ-016 SHALL, in ACQUIRE on a valid sample equal to expected, increment good and go to LOCKED when good reaches LOCK_COUNT.
REQ-017 SHALL, in ACQUIRE on a valid mismatch, stay in ACQUIRE with good=1, without pulsing err.
REQ-018 SHALL, in LOCKED on a valid mismatch, pulse err, increment err_count, go to ACQUIRE with good=1, and deassert locked.
REQ-019 SHALL, on every valid sample in every state, update expected=ramp+1 mod 2^WIDTH, so the checker resynchronises to the new sequence.
REQ-020 SHALL treat 0xFFFF followed by 0x0000 as a correct sample; in LOCKED this increments wrap_count.
REQ-021 SHALL saturate err_count and wrap_count at 2^CNT_W-1 with no wrap.
REQ-022 SHALL register all outputs: err, locked, and the counters reflect a sample on the clock edge after that sample is presented (latency 1).
REQ-023 SHALL keep err and timeout low in all cycles other than the single pulse cycle.
REQ-024 SHALL ignore the ramp value when ramp_valid=0.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, force state=UNLOCKED, expected=0, good=0, idle counter=0, locked=0, err=0, timeout=0, err_count=0, wrap_count=0.
REQ-026 SHALL give rst priority over ramp_valid; a sample presented in a reset cycle is discarded.
REQ-027 SHALL, on reset mid-lock, require full reacquisition (LOCK_COUNT samples) after rst falls.

Configuration
REQ-028 SHALL use the macro RAMP_CHECKER_TIMEOUT_EN to select the idle-timeout feature.
REQ-029 SHALL, without the macro, tie timeout to 0 and never leave LOCKED because of idle cycles.
REQ-030 SHALL, with the macro, count consecutive ramp_valid=0 cycles in LOCKED; on reaching TIMEOUT, go to UNLOCKED, pulse timeout, and deassert locked; any valid sample clears the count.

Verification
REQ-031 SHALL test this case: reset, then a continuous ramp 0x0000,0x0001,... -> locked rises on the edge after the 4th sample; err_count=0.
REQ-032 SHALL test this case: locked, then 0x0010 followed by 0x0013 -> one err pulse, err_count=1, locked=0, relock after 0x0014..0x0016 (4 correct samples total including 0x0013).
REQ-033 SHALL test this case: locked at 0xFFFE,0xFFFF,0x0000,0x0001 -> wrap_count=1, no err.
REQ-034 SHALL test this case: locked with ramp_valid toggling 1,0,1,0 on consecutive values -> no err, locked stays 1; with macro and TIMEOUT=8, 8 idle cycles -> timeout pulse, locked=0.
REQ-035 SHALL test this case: rst pulsed for 1 cycle while locked with err_count=3 -> all outputs 0 next cycle, and relock requires 4 samples.
REQ-036 SHALL test this case: CNT_W=2 with 5 injected mismatches in LOCKED -> err_count stays at 3.
